// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory bank and its storage array.
// Holds the FSM state encoding and the RamEnable/RamWrite strobe levels.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic RAM_ENABLE = 1'b1;
  localparam logic RAM_WRITE  = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_ADDR_W = 32;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane writeable word array: synchronous write, combinational read at idx.
// No reset; contents persist across bank resets.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int LANES  = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_bank.sv
// Single-port data memory bank, valid/ready request -> response, latency 1, full throughput.
// Held response stalls new requests until drained; DMEM_ALIGN_CHECK_EN flags misaligned accesses.
module data_mem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              is_write;
  logic              misaligned;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_addr;

  // High address bits above the index are intentionally ignored (aliasing).
  assign mem_idx     = req_addr[OFF_W +: IDX_W];
  assign unused_addr = ^req_addr;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (req_be),
    .idx   (mem_idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    req_ready = ~rst & (ce == RAM_ENABLE) & ((state_q == IDLE) | rsp_ready);
    accept    = req_valid & req_ready;
    is_write  = (req_we == RAM_WRITE);
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = |(req_addr & ADDR_W'(LANES - 1));
`else
    misaligned = 1'b0;
`endif
    mem_we      = accept & is_write & ~misaligned;

    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? RESP : IDLE;
      default: state_d = IDLE;
    endcase

    // Read data is captured at acceptance, so a later write cannot disturb a held response.
    if (accept) begin
      rsp_rdata_d = (is_write | misaligned) ? '0 : mem_rdata;
      rsp_err_d   = misaligned;
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
